decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// Decode stage: register file, instruction decoder and D/E pipeline register.
// Optional same-cycle write-back bypass on the read ports: define DECODE_BYPASS_EN.
module decode_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     Instr_D,
  input  logic [XLEN-1:0] PC_D,
  input  logic            valid_D,
  input  logic            stall,
  input  logic            flush,
  input  logic            RegWrite_W,
  input  logic [4:0]      Rd_W,
  input  logic [XLEN-1:0] Result_W,
  output logic [XLEN-1:0] RD1_E,
  output logic [XLEN-1:0] RD2_E,
  output logic [XLEN-1:0] Imm_E,
  output logic [XLEN-1:0] PC_E,
  output logic [4:0]      Rs1_E,
  output logic [4:0]      Rs2_E,
  output logic [4:0]      Rd_E,
  output logic [3:0]      ALUControl_E,
  output logic            ALUSrc_E,
  output logic            RegWrite_E,
  output logic            MemRead_E,
  output logic            MemWrite_E,
  output logic            valid_E,
  output logic            illegal_E
);

  localparam logic [6:0] OpRType = 7'b0110011;
  localparam logic [6:0] OpIType = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluAnd  = 4'b0010;
  localparam logic [3:0] AluOr   = 4'b0011;
  localparam logic [3:0] AluXor  = 4'b0100;
  localparam logic [3:0] AluSll  = 4'b0101;
  localparam logic [3:0] AluSrl  = 4'b0110;
  localparam logic [3:0] AluSra  = 4'b0111;
  localparam logic [3:0] AluSlt  = 4'b1000;
  localparam logic [3:0] AluSltu = 4'b1001;

  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;

  assign opcode    = Instr_D[6:0];
  assign rd        = Instr_D[11:7];
  assign funct3    = Instr_D[14:12];
  assign rs1       = Instr_D[19:15];
  assign rs2       = Instr_D[24:20];
  assign funct7_b5 = Instr_D[30];

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] rf_q [NREG];
  logic            rf_we;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;

  assign rf_we = RegWrite_W && (Rd_W != 5'd0) && (int'(Rd_W) < NREG);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (rf_we) begin
      rf_q[Rd_W] <= Result_W;
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if ((rs1 != 5'd0) && (int'(rs1) < NREG)) begin
      rd1 = rf_q[rs1];
    end
    if ((rs2 != 5'd0) && (int'(rs2) < NREG)) begin
      rd2 = rf_q[rs2];
    end
`ifdef DECODE_BYPASS_EN
    if (rf_we && (Rd_W == rs1)) begin
      rd1 = Result_W;
    end
    if (rf_we && (Rd_W == rs2)) begin
      rd2 = Result_W;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Decoder
  // ---------------------------------------------------------------------------
  // Only R-type uses funct7[5] for ADD/SUB; both R-type and shift-immediates use it for SRL/SRA.
  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt, input logic is_r);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (is_r && alt) ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] dec_imm;
  logic [3:0]      dec_alu;
  logic            dec_alu_src;
  logic            dec_reg_write;
  logic            dec_mem_read;
  logic            dec_mem_write;
  logic            dec_illegal;

  assign imm_i = {{(XLEN-12){Instr_D[31]}}, Instr_D[31:20]};
  assign imm_s = {{(XLEN-12){Instr_D[31]}}, Instr_D[31:25], Instr_D[11:7]};

  always_comb begin
    dec_imm       = '0;
    dec_alu       = AluAdd;
    dec_alu_src   = 1'b0;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_illegal   = 1'b0;
    case (opcode)
      OpRType: begin
        dec_alu       = alu_sel(funct3, funct7_b5, 1'b1);
        dec_reg_write = 1'b1;
      end
      OpIType: begin
        dec_alu       = alu_sel(funct3, funct7_b5, 1'b0);
        dec_imm       = imm_i;
        dec_alu_src   = 1'b1;
        dec_reg_write = 1'b1;
      end
      OpLoad: begin
        dec_imm       = imm_i;
        dec_alu_src   = 1'b1;
        dec_reg_write = 1'b1;
        dec_mem_read  = 1'b1;
      end
      OpStore: begin
        dec_imm       = imm_s;
        dec_alu_src   = 1'b1;
        dec_mem_write = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // D/E pipeline register: flush beats stall beats load
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RD1_E        <= '0;
      RD2_E        <= '0;
      Imm_E        <= '0;
      PC_E         <= '0;
      Rs1_E        <= '0;
      Rs2_E        <= '0;
      Rd_E         <= '0;
      ALUControl_E <= '0;
      ALUSrc_E     <= 1'b0;
      RegWrite_E   <= 1'b0;
      MemRead_E    <= 1'b0;
      MemWrite_E   <= 1'b0;
      valid_E      <= 1'b0;
      illegal_E    <= 1'b0;
    end else if (flush) begin
      // Data fields are don't-care in a bubble, so only the qualifiers are cleared.
      RegWrite_E   <= 1'b0;
      MemRead_E    <= 1'b0;
      MemWrite_E   <= 1'b0;
      valid_E      <= 1'b0;
      illegal_E    <= 1'b0;
    end else if (!stall) begin
      RD1_E        <= rd1;
      RD2_E        <= rd2;
      Imm_E        <= dec_imm;
      PC_E         <= PC_D;
      Rs1_E        <= rs1;
      Rs2_E        <= rs2;
      Rd_E         <= rd;
      ALUControl_E <= dec_alu;
      ALUSrc_E     <= dec_alu_src;
      RegWrite_E   <= valid_D & dec_reg_write;
      MemRead_E    <= valid_D & dec_mem_read;
      MemWrite_E   <= valid_D & dec_mem_write;
      valid_E      <= valid_D;
      illegal_E    <= valid_D & dec_illegal;
    end
  end

endmodule
